// File: rtl/game_controller.sv
// Game sequencer for the flappy-style game: player vertical physics,
// death detection, score keeping and the IDLE/PLAY/DYING/OVER state machine.
module game_controller #(
    parameter int START_H     = 240,
    parameter int TOP_LIMIT   = 10,
    parameter int BOT_LIMIT   = 420,
    parameter int GRAVITY     = 1,
    parameter int FLAP_VEL    = 8,
    parameter int VMAX        = 12,
    parameter int DEATH_TICKS = 60,
    parameter int SCORE_MAX   = 999
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               start,
    input  logic               flap,
    input  logic               pipe_hit,
    input  logic               score_inc,
    output logic [8:0]         height,
    output logic signed [5:0]  velocity,
    output logic               in_game,
    output logic               is_dead,
    output logic [9:0]         score,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int CNT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;

    localparam logic [8:0]        START_H9   = 9'(START_H);
    localparam logic [8:0]        TOP_LIM9   = 9'(TOP_LIMIT);
    localparam logic [8:0]        BOT_LIM9   = 9'(BOT_LIMIT);
    localparam logic signed [6:0] GRAVITY7   = 7'(GRAVITY);
    localparam logic signed [6:0] VMAX7      = 7'(VMAX);
    localparam logic signed [5:0] VMAX6      = 6'(VMAX);
    localparam logic signed [5:0] FLAP6      = 6'(FLAP_VEL);
    localparam logic [9:0]        SCORE_MAX10 = 10'(SCORE_MAX);
    localparam logic [CNT_W-1:0]  DEATH_LAST = CNT_W'(DEATH_TICKS - 1);

    state_t                state_q;
    state_t                state_nx;
    logic [8:0]            height_q;
    logic signed [5:0]     velocity_q;
    logic [9:0]            score_q;
    logic                  flap_pending_q;
    logic [CNT_W-1:0]      death_cnt_q;

    logic                  start_game;
    logic                  death_cond;
    logic                  dying_done;
    logic signed [5:0]     vel_nx;
    logic [8:0]            height_nx;

    // Flap overrides gravity; otherwise accelerate downward up to the terminal velocity.
    function automatic logic signed [5:0] next_velocity(input logic signed [5:0] v,
                                                         input logic do_flap);
        logic signed [6:0] sum;
        if (do_flap) begin
            return -FLAP6;
        end
        sum = $signed({v[5], v}) + GRAVITY7;
        if (sum > VMAX7) begin
            return VMAX6;
        end
        return sum[5:0];
    endfunction

    // Height update in 10-bit signed, clamped to the 9-bit screen range.
    // Physics only runs while alive (height <= BOT_LIMIT), so the sum stays
    // far below the 10-bit signed ceiling.
    function automatic logic [8:0] clamp_height(input logic [8:0] h,
                                                input logic signed [5:0] v);
        logic signed [9:0] sum;
        sum = $signed({1'b0, h}) + $signed({{4{v[5]}}, v});
        if (sum < 10'sd0) begin
            return 9'd0;
        end
        if (sum > 10'sd511) begin
            return 9'd511;
        end
        return sum[8:0];
    endfunction

    assign start_game = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign death_cond = (state_q == ST_PLAY) &&
                        ((height_q < TOP_LIM9) || (height_q > BOT_LIM9) || pipe_hit);
    assign dying_done = (state_q == ST_DYING) && tick && (death_cnt_q == DEATH_LAST);
    assign vel_nx     = next_velocity(velocity_q, flap_pending_q | flap);
    assign height_nx  = clamp_height(height_q, vel_nx);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE:  if (start)      state_nx = ST_PLAY;
            ST_PLAY:  if (death_cond) state_nx = ST_DYING;
            ST_DYING: if (dying_done) state_nx = ST_OVER;
            ST_OVER:  if (start)      state_nx = ST_PLAY;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Status flags decoded straight from the state register.
    always_comb begin
        in_game = 1'b0;
        is_dead = 1'b0;
        case (state_q)
            ST_PLAY:  in_game = 1'b1;
            ST_DYING: is_dead = 1'b1;
            ST_OVER:  is_dead = 1'b1;
            default:  ;
        endcase
    end

    // Player physics: initialise on start, step once per tick while alive in PLAY.
    always_ff @(posedge clk) begin
        if (reset) begin
            height_q       <= START_H9;
            velocity_q     <= '0;
            flap_pending_q <= 1'b0;
        end else if (start_game) begin
            height_q       <= START_H9;
            velocity_q     <= '0;
            flap_pending_q <= 1'b0;
        end else if ((state_q == ST_PLAY) && !death_cond) begin
            if (tick) begin
                velocity_q     <= vel_nx;
                height_q       <= height_nx;
                flap_pending_q <= 1'b0;
            end else if (flap) begin
                flap_pending_q <= 1'b1;
            end
        end
    end

    // Score: counts passed pipes in PLAY; a death on the same cycle drops the increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            score_q <= '0;
        end else if (start_game) begin
            score_q <= '0;
        end else if ((state_q == ST_PLAY) && !death_cond && score_inc) begin
            if (score_q < SCORE_MAX10) begin
                score_q <= score_q + 10'd1;
            end
        end
    end

    // Death animation timer: cleared on the fatal cycle, advanced by ticks in DYING.
    always_ff @(posedge clk) begin
        if (reset) begin
            death_cnt_q <= '0;
        end else if (death_cond) begin
            death_cnt_q <= '0;
        end else if ((state_q == ST_DYING) && tick) begin
            death_cnt_q <= death_cnt_q + 1'b1;
        end
    end

    assign height   = height_q;
    assign velocity = velocity_q;
    assign score    = score_q;
    assign state    = state_q;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: stimulus pushes expected post-edge
// outputs into a queue; a monitor pops one entry per clock and compares.
module tb_game_controller;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick = 1'b0;
    logic              start = 1'b0;
    logic              flap = 1'b0;
    logic              pipe_hit = 1'b0;
    logic              score_inc = 1'b0;
    logic [8:0]        height;
    logic signed [5:0] velocity;
    logic              in_game;
    logic              is_dead;
    logic [9:0]        score;
    logic [1:0]        state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int    st;
        int    h;
        int    v;
        int    sc;
        string name;
    } exp_t;

    exp_t exp_q[$];

    game_controller dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .start     (start),
        .flap      (flap),
        .pipe_hit  (pipe_hit),
        .score_inc (score_inc),
        .height    (height),
        .velocity  (velocity),
        .in_game   (in_game),
        .is_dead   (is_dead),
        .score     (score),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input string fld, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, req);
        end
    endtask

    // Monitor: one expected entry per clock, sampled 1ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, "state",    int'(state),    e.st);
                check(e.name, "height",   int'(height),   e.h);
                check(e.name, "velocity", int'(velocity), e.v);
                check(e.name, "score",    int'(score),    e.sc);
                check(e.name, "in_game",  int'(in_game),  (e.st == 1) ? 1 : 0);
                check(e.name, "is_dead",  int'(is_dead),  (e.st >= 2) ? 1 : 0);
            end
        end
    end

    task automatic push(input int st, input int h, input int v, input int sc, input string nm);
        exp_t e;
        e.st = st; e.h = h; e.v = v; e.sc = sc; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit t, input bit f, input bit s, input bit si, input bit ph);
        @(negedge clk);
        reset = 1'b0; tick = t; flap = f; start = s; score_inc = si; pipe_hit = ph;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; tick = 1'b0; flap = 1'b0; start = 1'b0; score_inc = 1'b0; pipe_hit = 1'b0;
    endtask

    initial begin
        int eh;
        int ev;

        // Reset state
        do_reset();
        push(0, 240, 0, 0, "reset");

        // Pulses in IDLE are ignored
        step(1, 1, 0, 1, 0); push(0, 240, 0, 0, "idle_ign1");
        step(1, 0, 0, 1, 0); push(0, 240, 0, 0, "idle_ign2");

        // Free fall, no flaps
        step(0, 0, 1, 0, 0); push(1, 240, 0, 0, "fall_start");
        for (int n = 1; n <= 21; n++) begin
            step(1, 0, 0, 0, 0);
            eh = (n <= 12) ? 240 + n * (n + 1) / 2 : 318 + 12 * (n - 12);
            ev = (n < 12) ? n : 12;
            push(1, eh, ev, 0, $sformatf("fall_t%0d", n));
        end
        step(0, 0, 0, 0, 0); push(2, 426, 12, 0, "fall_dying");

        // Reset mid-PLAY
        do_reset(); push(0, 240, 0, 0, "reset2");
        step(0, 0, 1, 0, 0); push(1, 240, 0, 0, "mid_start");
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 1, 0); push(1, 240, 0, i, $sformatf("mid_sc%0d", i));
        end
        for (int n = 1; n <= 10; n++) begin
            step(1, 0, 0, 0, 0);
            push(1, 240 + n * (n + 1) / 2, n, 5, $sformatf("mid_t%0d", n));
        end
        do_reset(); push(0, 240, 0, 0, "mid_reset");

        // Single flap before the first tick
        step(0, 0, 1, 0, 0); push(1, 240, 0, 0, "flap_start");
        step(0, 1, 0, 0, 0); push(1, 240, 0, 0, "flap_pend");
        step(1, 0, 0, 0, 0); push(1, 232, -8, 0, "flap_t1");
        step(1, 0, 0, 0, 0); push(1, 225, -7, 0, "flap_t2");
        step(1, 1, 0, 0, 0); push(1, 217, -8, 0, "flap_tick_same");

        // Flap on every tick until the ceiling kills the player
        do_reset(); push(0, 240, 0, 0, "reset3");
        step(0, 0, 1, 0, 0); push(1, 240, 0, 0, "ceil_start");
        for (int n = 1; n <= 29; n++) begin
            step(1, 1, 0, 0, 0);
            push(1, 240 - 8 * n, -8, 0, $sformatf("ceil_t%0d", n));
        end
        step(0, 0, 0, 0, 0); push(2, 8, -8, 0, "ceil_dying");
        step(1, 1, 1, 1, 0); push(2, 8, -8, 0, "dying_ign");

        // Scoring, pipe death dropping a simultaneous score_inc, DYING timeout, restart
        do_reset(); push(0, 240, 0, 0, "reset4");
        step(0, 0, 1, 0, 0); push(1, 240, 0, 0, "sc_start");
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 1, 0); push(1, 240, 0, i, $sformatf("sc_inc%0d", i));
        end
        step(0, 0, 0, 1, 1); push(2, 240, 0, 3, "pipe_death");
        step(0, 1, 1, 1, 0); push(2, 240, 0, 3, "dying_ign2");
        for (int k = 1; k <= 60; k++) begin
            step(1, 0, 0, 0, 0);
            push((k == 60) ? 3 : 2, 240, 0, 3, $sformatf("dying_t%0d", k));
        end
        step(1, 1, 0, 1, 0); push(3, 240, 0, 3, "over_hold");
        step(0, 0, 1, 0, 0); push(1, 240, 0, 0, "restart");

        // Score saturation
        for (int i = 1; i <= 1000; i++) begin
            step(0, 0, 0, 1, 0);
            push(1, 240, 0, (i < 999) ? i : 999, $sformatf("sat_%0d", i));
        end

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
Top-level game sequencer for the flappy-style game. It owns the player's vertical position and velocity, and applies gravity and flap physics once per frame tick. It detects out-of-bounds and pipe collisions, keeps score, and runs the IDLE/PLAY/DYING/OVER state machine. Its outputs `height`, `in_game` and `is_dead` drive the renderer and the pipe/score logic.

Parameters:
- START_H, 240: player top height loaded on game start (screen y; larger value is lower on screen).
- TOP_LIMIT, 10: player dies when height < TOP_LIMIT.
- BOT_LIMIT, 420: player dies when height > BOT_LIMIT.
- GRAVITY, 1: velocity added per tick while falling.
- FLAP_VEL, 8: upward velocity magnitude set by a flap.
- VMAX, 12: maximum downward velocity.
- DEATH_TICKS, 60: ticks spent in DYING before OVER.
- SCORE_MAX, 999: score saturation value.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- tick, input, 1: one-clk frame pulse (60 Hz).
- start, input, 1: one-clk pulse; begins a game from IDLE or OVER.
- flap, input, 1: one-clk debounced button pulse.
- pipe_hit, input, 1: level; player overlaps a pipe.
- score_inc, input, 1: one-clk pulse; a pipe was passed.
- height, output, 9: registered player top height.
- velocity, output, 6: registered signed velocity; negative means upward.
- in_game, output, 1: 1 in PLAY only.
- is_dead, output, 1: 1 in DYING and OVER.
- score, output, 10: registered score.
- state, output, 2: IDLE=0, PLAY=1, DYING=2, OVER=3.

Behaviour:
- Reset (any state, any cycle) sets:
  - state=IDLE, height=START_H, velocity=0, score=0;
  - flap_pending=0, death counter=0;
  - in_game=0, is_dead=0.
- All outputs are registered; `in_game` and `is_dead` are decoded from the state register.
- IDLE:
  - height holds START_H; flap, tick and score_inc are ignored.
  - start → PLAY next edge; height=START_H, velocity=0, score=0, flap_pending=0.
- PLAY:
  - A flap pulse sets flap_pending.
  - On a tick cycle, velocity_next = -FLAP_VEL if (flap_pending | flap), else min(velocity+GRAVITY, VMAX).
  - On the same edge, height_next = height + velocity_next. Compute in 10-bit signed, then clamp to 0..511.
  - flap_pending clears on every tick edge.
  - Height and velocity change only on tick cycles.
- Death check (PLAY, every clk, on registered values): if height < TOP_LIMIT, or height > BOT_LIMIT, or pipe_hit=1:
  - next edge → DYING;
  - death counter=0;
  - height and velocity freeze.
- Score: score_inc in PLAY with no death condition that cycle → score+1, saturating at SCORE_MAX. Death has priority: a score_inc on the death cycle is dropped.
- DYING:
  - Each tick increments the death counter.
  - When the counter reaches DEATH_TICKS-1 on a tick, the next edge → OVER.
  - start, flap and score_inc are ignored.
- OVER:
  - height and score hold for display.
  - start → PLAY with the same initialisation as from IDLE.
- Simultaneous events:
  - start and tick in the IDLE/OVER cycle: only initialisation happens, no physics that cycle.
  - flap and tick in the same cycle: the flap applies.
  - reset overrides everything.
- Latency: a tick changes height one clk later. A death condition sets is_dead one clk later.

Test Plan:
- Reset mid-PLAY (height ≈ 300, score = 5) → next clk: state=0, height=240, score=0, velocity=0, is_dead=0.
- Start, then no flaps → heights after ticks 1..12 are 241, 243, ..., 318.
  - Velocity saturates at 12; tick 20 gives height=414, tick 21 gives height=426.
  - The next clk shows state=DYING and is_dead=1.
- Start, flap before tick 1, then idle → tick 1 gives velocity=-8, height=232; tick 2 gives velocity=-7, height=225.
- Start, flap every tick → height decreases by 8 per tick; tick 29 gives height=8, then DYING.
- In PLAY, three score_inc pulses, then pipe_hit=1 together with a fourth score_inc → score=3 and DYING.
  - 60 ticks later the block is in OVER.
  - A start pulse then gives PLAY, score=0, height=240.
- Flap, tick and score_inc pulses in IDLE → no change to height, velocity or score.
